// File: rtl/simproc_pkg.sv
// Shared command codes, response bytes and controller states for the simproc host-command path.
package simproc_pkg;

    localparam logic [7:0] RESP_PING = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h4B;
    localparam logic [7:0] RESP_NAK  = 8'h3F;

    typedef enum logic [7:0] {
        CMD_PING   = 8'h01,
        CMD_WRITE  = 8'h02,
        CMD_READ   = 8'h03,
        CMD_RUN    = 8'h04,
        CMD_HALT   = 8'h05,
        CMD_STEP   = 8'h06,
        CMD_SET_PC = 8'h07,
        CMD_GET_PC = 8'h08
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_RESP,
        ST_WAIT_TX
    } state_e;

    // Response for every command except a READ that actually goes to memory.
    // Commands touching memory or the PC are refused while the core runs.
    function automatic logic [7:0] exec_resp(input logic [7:0] cmd,
                                             input logic       run,
                                             input logic [7:0] pc);
        case (cmd)
            CMD_PING:                         return RESP_PING;
            CMD_RUN, CMD_HALT:                return RESP_ACK;
            CMD_WRITE, CMD_STEP, CMD_SET_PC:  return run ? RESP_NAK : RESP_ACK;
            CMD_GET_PC:                       return pc;
            default:                          return RESP_NAK;
        endcase
    endfunction

endpackage

// File: rtl/simproc_cmd_ctrl_if.sv
// Host-command controller bus: UART byte side, memory port and core controls.
interface simproc_cmd_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              run;
    logic              step_pulse;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic [ADDR_W-1:0] pc_val;
    logic              busy;
    logic              overrun;

    modport master (
        input  rx_valid, rx_data, tx_done, mem_rdata, pc_val,
        output tx_en, tx_data, mem_addr, mem_wdata, mem_we, mem_re,
               run, step_pulse, pc_load, pc_load_val, busy, overrun
    );

    modport slave (
        output rx_valid, rx_data, tx_done, mem_rdata, pc_val,
        input  tx_en, tx_data, mem_addr, mem_wdata, mem_we, mem_re,
               run, step_pulse, pc_load, pc_load_val, busy, overrun
    );
endinterface

// File: rtl/simproc_frame_rx.sv
// Assembles cmd/addr/data byte frames; SIMPROC_CMD_TIMEOUT_EN adds an inter-byte timeout
// that discards a stalled partial frame.
module simproc_frame_rx #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_collect,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_frame_valid,
    output logic [7:0] o_cmd,
    output logic [7:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_timeout
);
    logic [1:0] r_idx;
    logic [7:0] r_cmd;
    logic [7:0] r_addr;
    logic       w_take;
    logic       w_timeout;

    assign w_take        = i_rx_valid && i_collect;
    assign o_frame_valid = w_take && (r_idx == 2'd2);
    assign o_cmd         = r_cmd;
    assign o_addr        = r_addr;
    assign o_data        = i_rx_data;
    assign o_timeout     = w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_cmd  <= 8'h00;
            r_addr <= 8'h00;
        end else if (w_timeout) begin
            r_idx <= 2'd0;
        end else if (w_take) begin
            case (r_idx)
                2'd0: begin
                    r_cmd <= i_rx_data;
                    r_idx <= 2'd1;
                end
                2'd1: begin
                    r_addr <= i_rx_data;
                    r_idx  <= 2'd2;
                end
                default: r_idx <= 2'd0;
            endcase
        end
    end

`ifdef SIMPROC_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Counts idle cycles only while a frame is partially received.
    always_ff @(posedge clk) begin
        if (rst || (r_idx == 2'd0) || i_rx_valid) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_idx != 2'd0) && !i_rx_valid &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign w_timeout        = 1'b0;
`endif

endmodule

// File: rtl/simproc_cmd_ctrl.sv
// Host-command sequencer: 3-byte frames in, one response byte out, memory/core control.
// Optional inter-byte timeout enabled by defining SIMPROC_CMD_TIMEOUT_EN.
module simproc_cmd_ctrl
    import simproc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    simproc_cmd_ctrl_if.master  bus
);
    state_e            r_state;
    logic [7:0]        r_cmd;
    logic              r_run;
    logic              r_overrun;
    logic              r_tx_en;
    logic [7:0]        r_tx_data;
    logic              r_mem_we;
    logic              r_mem_re;
    logic              r_step;
    logic              r_pc_load;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [ADDR_W-1:0] r_pc_load_val;

    logic       w_collect;
    logic       w_frame_valid;
    logic       w_timeout;
    logic [7:0] w_cmd;
    logic [7:0] w_addr;
    logic [7:0] w_data;

    assign w_collect = (r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                       (r_state == ST_GET_DATA);

    simproc_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk           (clk),
        .rst           (rst),
        .i_collect     (w_collect),
        .i_rx_valid    (bus.rx_valid),
        .i_rx_data     (bus.rx_data),
        .o_frame_valid (w_frame_valid),
        .o_cmd         (w_cmd),
        .o_addr        (w_addr),
        .o_data        (w_data),
        .o_timeout     (w_timeout)
    );

    // Side-effect strobes are registered on the frame-complete edge so they are
    // visible during EXEC; read data then arrives in MEM_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cmd         <= 8'h00;
            r_run         <= 1'b0;
            r_overrun     <= 1'b0;
            r_tx_en       <= 1'b0;
            r_tx_data     <= 8'h00;
            r_mem_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_step        <= 1'b0;
            r_pc_load     <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_pc_load_val <= '0;
        end else begin
            r_tx_en   <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_re  <= 1'b0;
            r_step    <= 1'b0;
            r_pc_load <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_valid) r_state <= ST_GET_ADDR;
                end
                ST_GET_ADDR: begin
                    if (w_timeout)         r_state <= ST_IDLE;
                    else if (bus.rx_valid) r_state <= ST_GET_DATA;
                end
                ST_GET_DATA: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (w_frame_valid) begin
                        r_cmd         <= w_cmd;
                        r_mem_addr    <= ADDR_W'(w_addr);
                        r_mem_wdata   <= DATA_W'(w_data);
                        r_pc_load_val <= ADDR_W'(w_addr);
                        if (!r_run) begin
                            case (w_cmd)
                                CMD_WRITE:  r_mem_we  <= 1'b1;
                                CMD_READ:   r_mem_re  <= 1'b1;
                                CMD_STEP:   r_step    <= 1'b1;
                                CMD_SET_PC: r_pc_load <= 1'b1;
                                default:    ;
                            endcase
                        end
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (r_cmd)
                        CMD_PING: r_overrun <= 1'b0;
                        CMD_RUN:  r_run     <= 1'b1;
                        CMD_HALT: r_run     <= 1'b0;
                        default:  ;
                    endcase
                    if ((r_cmd == CMD_READ) && !r_run) begin
                        r_state <= ST_MEM_WAIT;
                    end else begin
                        r_tx_data <= exec_resp(r_cmd, r_run, bus.pc_val[7:0]);
                        r_tx_en   <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_MEM_WAIT: begin
                    r_tx_data <= bus.mem_rdata[7:0];
                    r_tx_en   <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (bus.tx_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // A byte outside the collecting states is lost; this wins over a PING clear.
            if (bus.rx_valid && !w_collect) r_overrun <= 1'b1;
        end
    end

    assign bus.tx_en       = r_tx_en;
    assign bus.tx_data     = r_tx_data;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_re      = r_mem_re;
    assign bus.run         = r_run;
    assign bus.step_pulse  = r_step;
    assign bus.pc_load     = r_pc_load;
    assign bus.pc_load_val = r_pc_load_val;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_simproc_cmd_ctrl.sv
// Directed bench for simproc_cmd_ctrl: frame vector table plus reset/overrun/timeout sequences.
module tb_simproc_cmd_ctrl;
    import simproc_pkg::*;

`ifdef SIMPROC_CMD_TIMEOUT_EN
    localparam int TO_CYC = 64;
`else
    localparam int TO_CYC = 4096;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    simproc_cmd_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    simproc_cmd_ctrl #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Memory and core PC models.
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.mem_rdata = 8'h00;
        bus.pc_val    = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1)  mem[bus.mem_addr] = bus.mem_wdata;
            if (bus.mem_re === 1'b1)  bus.mem_rdata = mem[bus.mem_addr];
            if (bus.pc_load === 1'b1) bus.pc_val = bus.pc_load_val;
        end
    end

    // Strobe monitor: pulse counts and back-to-back detection.
    int         n_we, n_re, n_step, n_pcl, n_tx, n_viol;
    logic [7:0] last_we_addr, last_we_data, last_pcl_val;
    logic       p_we, p_re, p_step, p_pcl, p_tx;
    initial begin
        n_we = 0; n_re = 0; n_step = 0; n_pcl = 0; n_tx = 0; n_viol = 0;
        p_we = 0; p_re = 0; p_step = 0; p_pcl = 0; p_tx = 0;
        last_we_addr = 0; last_we_data = 0; last_pcl_val = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                n_we++; last_we_addr = bus.mem_addr; last_we_data = bus.mem_wdata;
                if (p_we) n_viol++;
            end
            if (bus.mem_re === 1'b1) begin n_re++; if (p_re) n_viol++; end
            if (bus.step_pulse === 1'b1) begin n_step++; if (p_step) n_viol++; end
            if (bus.pc_load === 1'b1) begin
                n_pcl++; last_pcl_val = bus.pc_load_val;
                if (p_pcl) n_viol++;
            end
            if (bus.tx_en === 1'b1) begin n_tx++; if (p_tx) n_viol++; end
            p_we = (bus.mem_we === 1'b1);   p_re = (bus.mem_re === 1'b1);
            p_step = (bus.step_pulse === 1'b1); p_pcl = (bus.pc_load === 1'b1);
            p_tx = (bus.tx_en === 1'b1);
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Third byte, then wait (bounded) for tx_en; lat = -1 if it never comes.
    task automatic last_byte(input logic [7:0] b, output logic [7:0] resp, output int lat);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        lat = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.rx_valid = 1'b0;
            lat++;
            if (bus.tx_en === 1'b1) break;
        end
        if (bus.tx_en !== 1'b1) lat = -1;
        resp = bus.tx_data;
    endtask

    task automatic finish_frame();
        repeat (3) @(posedge clk);
        #1;
        bus.tx_done = 1'b1;
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] b0, b1, b2, output logic [7:0] resp, output int lat);
        send_byte(b0);
        send_byte(b1);
        last_byte(b2, resp, lat);
        finish_frame();
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [7:0] resp;
        int         lat;
        int         we, re, step, pcl;
        logic       run;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin : main
        logic [7:0] resp;
        int         lat;
        int         s_we, s_re, s_step, s_pcl, s_tx;

        //            b0     b1     b2     resp   lat we re st pcl run
        vecs[0]  = '{8'h01, 8'h00, 8'h00, 8'hA5, 2, 0, 0, 0, 0, 1'b0};
        vecs[1]  = '{8'h02, 8'h00, 8'h05, 8'h4B, 2, 1, 0, 0, 0, 1'b0};
        vecs[2]  = '{8'h03, 8'h00, 8'h00, 8'h05, 3, 0, 1, 0, 0, 1'b0};
        vecs[3]  = '{8'h04, 8'h10, 8'h00, 8'h4B, 2, 0, 0, 0, 0, 1'b1};
        vecs[4]  = '{8'h06, 8'h10, 8'h00, 8'h3F, 2, 0, 0, 0, 0, 1'b1};
        vecs[5]  = '{8'h02, 8'h01, 8'h07, 8'h3F, 2, 0, 0, 0, 0, 1'b1};
        vecs[6]  = '{8'h03, 8'h00, 8'h00, 8'h3F, 2, 0, 0, 0, 0, 1'b1};
        vecs[7]  = '{8'h04, 8'h00, 8'h00, 8'h4B, 2, 0, 0, 0, 0, 1'b1};
        vecs[8]  = '{8'h05, 8'h10, 8'h00, 8'h4B, 2, 0, 0, 0, 0, 1'b0};
        vecs[9]  = '{8'h06, 8'h10, 8'h00, 8'h4B, 2, 0, 0, 1, 0, 1'b0};
        vecs[10] = '{8'h07, 8'h79, 8'h00, 8'h4B, 2, 0, 0, 0, 1, 1'b0};
        vecs[11] = '{8'h08, 8'h79, 8'h00, 8'h79, 2, 0, 0, 0, 0, 1'b0};
        vecs[12] = '{8'h08, 8'h00, 8'h00, 8'h79, 2, 0, 0, 0, 0, 1'b0};
        vecs[13] = '{8'hEE, 8'h00, 8'h00, 8'h3F, 2, 0, 0, 0, 0, 1'b0};
        vecs[14] = '{8'h03, 8'h01, 8'h00, 8'h00, 3, 0, 1, 0, 0, 1'b0};
        vecs[15] = '{8'h02, 8'hFF, 8'h5A, 8'h4B, 2, 1, 0, 0, 0, 1'b0};
        vecs[16] = '{8'h03, 8'hFF, 8'h00, 8'h5A, 3, 0, 1, 0, 0, 1'b0};
        vecs[17] = '{8'h04, 8'h00, 8'h00, 8'h4B, 2, 0, 0, 0, 0, 1'b1};
        vecs[18] = '{8'h07, 8'h33, 8'h00, 8'h3F, 2, 0, 0, 0, 0, 1'b1};
        vecs[19] = '{8'h08, 8'h00, 8'h00, 8'h79, 2, 0, 0, 0, 0, 1'b1};
        vecs[20] = '{8'h05, 8'h00, 8'h00, 8'h4B, 2, 0, 0, 0, 0, 1'b0};

        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_en",    bus.tx_en,    0);
        check("reset tx_data",  bus.tx_data,  0);
        check("reset strobes",  {bus.mem_we, bus.mem_re, bus.step_pulse, bus.pc_load}, 0);
        check("reset run",      bus.run,      0);
        check("reset busy",     bus.busy,     0);
        check("reset overrun",  bus.overrun,  0);
        check("reset mem_addr", bus.mem_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            s_we = n_we; s_re = n_re; s_step = n_step; s_pcl = n_pcl; s_tx = n_tx;
            run_frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, resp, lat);
            check($sformatf("v%0d resp", v),    resp,             vecs[v].resp);
            check($sformatf("v%0d latency", v), lat,              vecs[v].lat);
            check($sformatf("v%0d busy", v),    bus.busy,         0);
            check($sformatf("v%0d tx_en n", v), n_tx - s_tx,      1);
            check($sformatf("v%0d we n", v),    n_we - s_we,      vecs[v].we);
            check($sformatf("v%0d re n", v),    n_re - s_re,      vecs[v].re);
            check($sformatf("v%0d step n", v),  n_step - s_step,  vecs[v].step);
            check($sformatf("v%0d pcl n", v),   n_pcl - s_pcl,    vecs[v].pcl);
            check($sformatf("v%0d run", v),     bus.run,          vecs[v].run);
            if (vecs[v].we != 0) begin
                check($sformatf("v%0d we addr", v), last_we_addr, vecs[v].b1);
                check($sformatf("v%0d we data", v), last_we_data, vecs[v].b2);
            end
            if (vecs[v].pcl != 0)
                check($sformatf("v%0d pc_load_val", v), last_pcl_val, vecs[v].b1);
        end

        // Extra byte during response phase sets overrun; PING clears it.
        send_byte(8'hEE); send_byte(8'h00);
        last_byte(8'h00, resp, lat);
        check("ovr resp", resp, 8'h3F);
        check("ovr before", bus.overrun, 0);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h01;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        check("ovr set", bus.overrun, 1);
        check("ovr busy", bus.busy, 1);
        finish_frame();
        check("ovr idle", bus.busy, 0);
        run_frame(8'h01, 8'h00, 8'h00, resp, lat);
        check("ovr ping resp", resp, 8'hA5);
        check("ovr cleared", bus.overrun, 0);

        // Byte landing with tx_done is dropped.
        send_byte(8'h01); send_byte(8'h00);
        last_byte(8'h00, resp, lat);
        @(posedge clk); #1;
        bus.tx_done = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h02;
        @(posedge clk); #1;
        bus.tx_done = 1'b0; bus.rx_valid = 1'b0;
        check("drop busy", bus.busy, 0);
        check("drop overrun", bus.overrun, 1);
        run_frame(8'h01, 8'h00, 8'h00, resp, lat);
        check("drop ping resp", resp, 8'hA5);

        // Reset after two bytes discards the partial frame.
        send_byte(8'h02); send_byte(8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst1 busy", bus.busy, 0);
        check("rst1 run", bus.run, 0);
        s_we = n_we;
        run_frame(8'h01, 8'h00, 8'h00, resp, lat);
        check("rst1 ping resp", resp, 8'hA5);
        check("rst1 no write", n_we - s_we, 0);

        // Reset during WAIT_TX while running.
        run_frame(8'h04, 8'h00, 8'h00, resp, lat);
        check("rst2 run on", bus.run, 1);
        send_byte(8'h08); send_byte(8'h55);
        last_byte(8'h00, resp, lat);
        @(posedge clk); #1;
        s_tx = n_tx;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2 run", bus.run, 0);
        check("rst2 busy", bus.busy, 0);
        check("rst2 tx_data", bus.tx_data, 0);
        check("rst2 mem_addr", bus.mem_addr, 0);
        repeat (5) @(posedge clk);
        #1;
        check("rst2 no tx_en", n_tx - s_tx, 0);
        run_frame(8'h01, 8'h00, 8'h00, resp, lat);
        check("rst2 ping resp", resp, 8'hA5);

        // One-byte stall of 100 cycles.
        s_tx = n_tx;
        send_byte(8'h01);
        repeat (100) @(posedge clk);
        #1;
`ifdef SIMPROC_CMD_TIMEOUT_EN
        check("timeout busy", bus.busy, 0);
        check("timeout no tx", n_tx - s_tx, 0);
        run_frame(8'h01, 8'h00, 8'h00, resp, lat);
        check("timeout ping resp", resp, 8'hA5);
`else
        check("stall busy", bus.busy, 1);
        send_byte(8'h00);
        last_byte(8'h00, resp, lat);
        finish_frame();
        check("stall resp", resp, 8'hA5);
        check("stall tx n", n_tx - s_tx, 1);
`endif

        check("strobe single cycle", n_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

endmodule
